// File: rtl/cache_refill_arbiter.sv
// rtl/cache_refill_arbiter.sv - Icache/Dcache line-transfer arbiter for the shared memory bus
//
// Grants the external memory bus to one cache at a time and runs a fixed
// LINE_WORDS-beat burst for the granted line (Icache refill, Dcache refill
// or Dcache writeback). When both caches request, Dcache wins unless it
// also won the previous grant.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   ic_req_i/ic_addr_i  Icache refill request (held until ic_ready_o) and miss address
//   dc_req_i/dc_we_i    Dcache request (held until dc_ready_o); 1 = writeback
//   dc_addr_i           Dcache line address
//   dc_wdata_i          writeback word for beat dc_beat_idx_o
//   mem_req_o/mem_we_o  bus beat request / beat is a write
//   mem_addr_o          word-aligned beat address
//   mem_wdata_o         write data (Dcache writeback only)
//   mem_ack_i           beat complete; read data valid in the same cycle
//   mem_rdata_i         read data
//   ic_beat_valid_o     Icache read beat valid
//   dc_beat_valid_o     Dcache read beat valid / write beat accepted
//   rdata_o             shared read beat data
//   dc_beat_idx_o       current beat index
//   ic_ready_o          one-cycle pulse, Icache transfer complete
//   dc_ready_o          one-cycle pulse, Dcache transfer complete
//   busy_o              arbiter is not idle

module cache_refill_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ic_req_i,
    input  logic [31:0]      ic_addr_i,
    input  logic             dc_req_i,
    input  logic             dc_we_i,
    input  logic [31:0]      dc_addr_i,
    input  logic [31:0]      dc_wdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             ic_beat_valid_o,
    output logic             dc_beat_valid_o,
    output logic [31:0]      rdata_o,
    output logic [CNT_W-1:0] dc_beat_idx_o,
    output logic             ic_ready_o,
    output logic             dc_ready_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IC_XFER,
        S_DC_XFER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(LINE_WORDS - 1);
    // Byte-offset bits inside one line; replaced by the beat counter.
    localparam logic [31:0]      OFFSET_MASK = 32'(LINE_WORDS * 4 - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    // 1 when the most recent grant went to Dcache; also selects which
    // ready pulse is produced in S_DONE.
    logic             last_dc;
    logic             last_dc_next;
    logic [31:0]      line_base;
    logic [31:0]      line_base_next;
    logic             we_q;
    logic             we_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_dc   <= 1'b0;
            line_base <= '0;
            we_q      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            last_dc   <= last_dc_next;
            line_base <= line_base_next;
            we_q      <= we_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        last_dc_next   = last_dc;
        line_base_next = line_base;
        we_next        = we_q;
        case (state)
            S_IDLE: begin
                // Dcache has priority, but yields to a waiting Icache
                // right after it has been served.
                if (dc_req_i && (!ic_req_i || !last_dc)) begin
                    state_next     = S_DC_XFER;
                    last_dc_next   = 1'b1;
                    line_base_next = dc_addr_i;
                    we_next        = dc_we_i;
                    cnt_next       = '0;
                end else if (ic_req_i) begin
                    state_next     = S_IC_XFER;
                    last_dc_next   = 1'b0;
                    line_base_next = ic_addr_i;
                    we_next        = 1'b0;
                    cnt_next       = '0;
                end
            end
            S_IC_XFER, S_DC_XFER: begin
                if (mem_ack_i) begin
                    if (cnt == LAST_BEAT) begin
                        state_next = S_DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    logic ic_xfer;
    logic dc_xfer;

    assign ic_xfer = (state == S_IC_XFER);
    assign dc_xfer = (state == S_DC_XFER);

    assign mem_req_o       = ic_xfer | dc_xfer;
    assign mem_we_o        = dc_xfer & we_q;
    assign mem_addr_o      = (line_base & ~OFFSET_MASK) | {{(30 - CNT_W){1'b0}}, cnt, 2'b00};
    assign mem_wdata_o     = (dc_xfer && we_q) ? dc_wdata_i : '0;
    assign ic_beat_valid_o = ic_xfer & mem_ack_i;
    assign dc_beat_valid_o = dc_xfer & mem_ack_i;
    assign rdata_o         = mem_rdata_i;
    assign dc_beat_idx_o   = cnt;
    assign ic_ready_o      = (state == S_DONE) & ~last_dc;
    assign dc_ready_o      = (state == S_DONE) & last_dc;
    assign busy_o          = (state != S_IDLE);

    // A requester must hold its request for the whole burst.
    ic_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_IC_XFER) |-> ic_req_i);
    dc_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_DC_XFER) |-> dc_req_i);

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb/tb_cache_refill_arbiter.sv - self-checking bench for cache_refill_arbiter

module tb_cache_refill_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req_i;
    logic [31:0] ic_addr_i;
    logic        dc_req_i;
    logic        dc_we_i;
    logic [31:0] dc_addr_i;
    logic [31:0] dc_wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        ic_beat_valid_o;
    logic        dc_beat_valid_o;
    logic [31:0] rdata_o;
    logic [1:0]  dc_beat_idx_o;
    logic        ic_ready_o;
    logic        dc_ready_o;
    logic        busy_o;

    cache_refill_arbiter #(.LINE_WORDS(LW), .CNT_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ic_req_i        (ic_req_i),
        .ic_addr_i       (ic_addr_i),
        .dc_req_i        (dc_req_i),
        .dc_we_i         (dc_we_i),
        .dc_addr_i       (dc_addr_i),
        .dc_wdata_i      (dc_wdata_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .ic_beat_valid_o (ic_beat_valid_o),
        .dc_beat_valid_o (dc_beat_valid_o),
        .rdata_o         (rdata_o),
        .dc_beat_idx_o   (dc_beat_idx_o),
        .ic_ready_o      (ic_ready_o),
        .dc_ready_o      (dc_ready_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Transaction-level model: who owns the bus, how many beats of the
    // line are done, and whether the completion cycle is in progress.
    int          m_owner = 0;   // 0 none, 1 Icache, 2 Dcache
    int          m_beat  = 0;
    bit          m_done  = 0;
    bit          m_last_dc = 0;
    bit          m_we    = 0;
    logic [31:0] m_base  = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_owner = 0; m_beat = 0; m_done = 0; m_last_dc = 0; m_we = 0; m_base = '0;
        end else if (m_owner == 0) begin
            if (dc_req_i && (!ic_req_i || !m_last_dc)) begin
                m_owner = 2; m_base = dc_addr_i & ~32'(LW * 4 - 1); m_we = dc_we_i; m_last_dc = 1;
            end else if (ic_req_i) begin
                m_owner = 1; m_base = ic_addr_i & ~32'(LW * 4 - 1); m_we = 0; m_last_dc = 0;
            end
        end else if (m_done) begin
            m_owner = 0;
            m_done  = 0;
        end else if (mem_ack_i) begin
            m_beat++;
            if (m_beat == LW) begin
                m_beat = 0;
                m_done = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_req;
        bit is_dc;
        exp_req = (m_owner != 0) && !m_done;
        is_dc   = (m_owner == 2);
        chk1("busy", busy_o, m_owner != 0);
        chk1("mem_req", mem_req_o, exp_req);
        chk1("ic_ready", ic_ready_o, m_done && m_owner == 1);
        chk1("dc_ready", dc_ready_o, m_done && is_dc);
        chk1("ic_beat_valid", ic_beat_valid_o, exp_req && m_owner == 1 && mem_ack_i);
        chk1("dc_beat_valid", dc_beat_valid_o, exp_req && is_dc && mem_ack_i);
        chk32("rdata", rdata_o, mem_rdata_i);
        chk32("beat_idx", 32'(dc_beat_idx_o), 32'(m_beat));
        chk32("wdata", mem_wdata_o, (exp_req && is_dc && m_we) ? dc_wdata_i : 32'h0);
        if (exp_req) begin
            chk32("mem_addr", mem_addr_o, m_base + 32'(4 * m_beat));
            chk1("mem_we", mem_we_o, is_dc && m_we);
        end
    end

    // Event logs used by the directed literal checks.
    logic [31:0] ack_addr[$];
    int          ack_cyc[$];
    int          grant_cyc[$];
    int          ready_who[$];
    int          ready_cyc[$];
    logic [31:0] ic_data[$];
    int          n_dc_strobe = 0;
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        if (mem_req_o && !prev_req) grant_cyc.push_back(cyc);
        prev_req = mem_req_o;
        if (mem_req_o && mem_ack_i) begin
            ack_addr.push_back(mem_addr_o);
            ack_cyc.push_back(cyc);
        end
        if (ic_beat_valid_o) ic_data.push_back(rdata_o);
        if (ic_ready_o) begin ready_who.push_back(1); ready_cyc.push_back(cyc); end
        if (dc_ready_o) begin ready_who.push_back(2); ready_cyc.push_back(cyc); end
        if (dc_beat_valid_o || dc_ready_o || mem_we_o) n_dc_strobe++;
    end

    task automatic clear_logs();
        ack_addr.delete(); ack_cyc.delete(); grant_cyc.delete();
        ready_who.delete(); ready_cyc.delete(); ic_data.delete();
        n_dc_strobe = 0;
    endtask

    int ack_mode = 0;   // 0 every cycle, 1 every other cycle, 2 random
    bit ack_ph   = 0;
    bit rd_pat   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        ack_ph = ~ack_ph;
        case (ack_mode)
            0:       mem_ack_i = 1'b1;
            1:       mem_ack_i = ack_ph;
            default: mem_ack_i = ($urandom_range(0, 2) != 0);
        endcase
        mem_rdata_i = rd_pat ? 32'hA0 + 32'(ack_addr.size()) : $urandom;
        dc_wdata_i  = $urandom;
    endtask

    task automatic wait_ready(input bit dc, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (dc ? dc_ready_o : ic_ready_o) return;
            tick();
        end
        chk1(dc ? "dc_ready timeout" : "ic_ready timeout", 1'b0, 1'b1);
    endtask

    task automatic chk_addrs(input string tag, input logic [31:0] base);
        chk32({tag, " beat count"}, 32'(ack_addr.size()), 32'(LW));
        for (int i = 0; i < LW; i++)
            if (i < ack_addr.size())
                chk32($sformatf("%s addr%0d", tag, i), ack_addr[i], base + 32'(4 * i));
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " mem_req"}, mem_req_o, 1'b0);
        chk1({tag, " mem_we"}, mem_we_o, 1'b0);
        chk32({tag, " mem_addr"}, mem_addr_o, 32'h0);
        chk32({tag, " mem_wdata"}, mem_wdata_o, 32'h0);
        chk1({tag, " ic_beat_valid"}, ic_beat_valid_o, 1'b0);
        chk1({tag, " dc_beat_valid"}, dc_beat_valid_o, 1'b0);
        chk32({tag, " beat_idx"}, 32'(dc_beat_idx_o), 32'h0);
        chk1({tag, " ic_ready"}, ic_ready_o, 1'b0);
        chk1({tag, " dc_ready"}, dc_ready_o, 1'b0);
        chk1({tag, " busy"}, busy_o, 1'b0);
    endtask

    initial begin
        bit ic_seen;
        bit dc_seen;
        rst_n = 1'b0; ic_req_i = 1'b0; ic_addr_i = '0; dc_req_i = 1'b0; dc_we_i = 1'b0;
        dc_addr_i = '0; dc_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Reset state
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Icache refill, zero-wait acks
        clear_logs();
        ack_mode = 0; ic_addr_i = 32'h0000_1234; ic_req_i = 1'b1;
        wait_ready(0, 50);
        tick();
        ic_req_i = 1'b0;
        chk1("t1 busy after done", busy_o, 1'b0);
        chk_addrs("t1", 32'h1230);
        if (ack_cyc.size() == LW && ready_cyc.size() == 1)
            chk32("t1 ready latency", 32'(ready_cyc[0] - ack_cyc[LW-1]), 32'd1);
        tick();

        // Dcache writeback, ack every other cycle
        clear_logs();
        ack_mode = 1; dc_addr_i = 32'h2000; dc_we_i = 1'b1; dc_req_i = 1'b1;
        wait_ready(1, 80);
        tick();
        dc_req_i = 1'b0; dc_we_i = 1'b0;
        chk_addrs("t2", 32'h2000);
        chk32("t2 ready count", 32'(ready_who.size()), 32'd1);
        if (ack_cyc.size() == LW)
            chk32("t2 ack spacing", 32'(ack_cyc[LW-1] - ack_cyc[0]), 32'd6);
        tick();

        // Icache read data pattern
        clear_logs();
        ack_mode = 0; rd_pat = 1; ic_addr_i = 32'h5008; ic_req_i = 1'b1;
        wait_ready(0, 50);
        tick();
        ic_req_i = 1'b0; rd_pat = 0;
        chk32("t4 beat count", 32'(ic_data.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < ic_data.size()) chk32($sformatf("t4 rdata%0d", i), ic_data[i], 32'hA0 + 32'(i));
        chk32("t4 dc strobes", 32'(n_dc_strobe), 32'd0);
        tick();

        // Reset in the middle of a Dcache refill
        clear_logs();
        ack_mode = 0; dc_addr_i = 32'h3000; dc_we_i = 1'b0; dc_req_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (ack_addr.size() >= 2) break;
        end
        rst_n = 1'b0;
        tick();
        chk_all_zero("t5 abort");
        rst_n = 1'b1;
        chk32("t5 no ready on abort", 32'(ready_who.size()), 32'd0);
        clear_logs();
        wait_ready(1, 50);
        tick();
        dc_req_i = 1'b0;
        chk_addrs("t5 restart", 32'h3000);
        chk32("t5 ready count", 32'(ready_who.size()), 32'd1);
        tick();

        // Both requesting from reset: DC, IC, DC
        rst_n = 1'b0; ack_mode = 2;
        ic_addr_i = 32'h6000; dc_addr_i = 32'h7000; dc_we_i = 1'b0;
        ic_req_i = 1'b1; dc_req_i = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        clear_logs();
        for (int k = 0; k < 300; k++) begin
            tick();
            if (ready_who.size() >= 3) break;
        end
        ic_req_i = 1'b0; dc_req_i = 1'b0;
        chk32("t3 grants", 32'(ready_who.size()), 32'd3);
        if (ready_who.size() >= 3) begin
            chk32("t3 first", 32'(ready_who[0]), 32'd2);
            chk32("t3 second", 32'(ready_who[1]), 32'd1);
            chk32("t3 third", 32'(ready_who[2]), 32'd2);
        end
        tick(); tick();

        // Four sequential Icache lines, request held continuously
        clear_logs();
        ack_mode = 0; ic_addr_i = 32'h4000; ic_req_i = 1'b1;
        for (int l = 0; l < 4; l++) begin
            wait_ready(0, 50);
            tick();
            if (l < 3) ic_addr_i = ic_addr_i + 32'd16;
            else       ic_req_i = 1'b0;
        end
        chk32("t6 grants", 32'(grant_cyc.size()), 32'd4);
        // Final ack in cycle A, then DONE and IDLE, so the next beat 0 is cycle A+3.
        for (int i = 1; i < 4; i++)
            if (grant_cyc.size() == 4 && ack_cyc.size() == 16) begin
                chk32($sformatf("t6 gap%0d", i), 32'(grant_cyc[i] - ack_cyc[4*i-1]), 32'd3);
                chk32($sformatf("t6 base%0d", i), ack_addr[4*i], 32'h4000 + 32'(16 * i));
            end
        chk32("t6 dc strobes", 32'(n_dc_strobe), 32'd0);
        tick();

        // Randomized traffic with protocol-following requesters
        ack_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ic_seen = ic_ready_o;
            dc_seen = dc_ready_o;
            tick();
            rst_n = ($urandom_range(0, 399) != 0);
            if (ic_seen) ic_req_i = 1'b0;
            else if (!ic_req_i && $urandom_range(0, 3) == 0) begin
                ic_req_i = 1'b1; ic_addr_i = $urandom;
            end
            if (dc_seen) dc_req_i = 1'b0;
            else if (!dc_req_i && $urandom_range(0, 3) == 0) begin
                dc_req_i = 1'b1; dc_addr_i = $urandom; dc_we_i = $urandom_range(0, 1) == 1;
            end
        end
        rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
